// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle for the sequential shifter.
// master drives start/op/A/B and receives busy/done/res; slave is the reverse.
// Signals: start (request strobe), op (shift select), A (operand),
// B (instruction word, amount in B[10:6]), busy, done (result-valid pulse), res.
interface shift_seq_ctrl_if #(
    parameter int DW = 32
);
    logic          start;
    logic [1:0]    op;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          busy;
    logic          done;
    logic [DW-1:0] res;

    modport master (
        output start, op, A, B,
        input  busy, done, res
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, res
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Purpose: multi-cycle barrel-less shifter (SLL/SRL/SRA) stepping the operand one bit per cycle.
// Latency: start sampled at edge t -> done pulse after edge t+s+1 (s = B[10:6]); s=0 gives t+1.
// Backpressure: start is ignored while busy=1; accepted in idle and in the done-pending cycle.
//
// Ports: clk (rising-edge clock), rst (synchronous active-high reset),
//        bus (shift_seq_ctrl_if.slave: start, op, A, B in; busy, done, res out).
// Optional feature: define SHIFT_SEQ_FAST4_EN to shift by 4 per cycle while cnt>=4
// (latency floor(s/4)+(s mod 4)+1); results are identical in both builds.
module shift_seq_ctrl #(
    parameter int DW  = 32,
    parameter int SAW = 5
) (
    input  logic            clk,
    input  logic            rst,
    shift_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    logic [DW-1:0]  wreg;
    logic [SAW-1:0] cnt;
    logic [1:0]     op_q;
    logic           busy_q;
    logic           done_q;
    logic [DW-1:0]  res_q;

    logic [SAW-1:0] amt;
    logic [SAW-1:0] step;
    logic [SAW-1:0] cnt_nxt;

    // Only the shift-amount field of the instruction word is used.
    assign amt = bus.B[6 +: SAW];

    logic unused_b;
    assign unused_b = ^{bus.B[DW-1:6+SAW], bus.B[5:0]};

    always_comb begin
        step = SAW'(1);
`ifdef SHIFT_SEQ_FAST4_EN
        if (cnt >= SAW'(4)) begin
            step = SAW'(4);
        end
`endif
        cnt_nxt = cnt - step;
    end

    function automatic logic [DW-1:0] shift_by(input logic [DW-1:0]  v,
                                               input logic [1:0]     o,
                                               input logic [SAW-1:0] n);
        case (o)
            2'b00:   shift_by = v << n;
            2'b10:   shift_by = $unsigned($signed(v) >>> n);
            default: shift_by = v >> n;   // SRL, and the reserved encoding behaves as SRL
        endcase
    endfunction

    // DONE is the cycle in which the working register holds the final value.
    // res/done are registered out of DONE, so they appear one cycle later,
    // which yields the s+1 cycle latency and keeps res stable across the
    // done pulse even when a back-to-back request is taken in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wreg   <= '0;
            cnt    <= '0;
            op_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                SHIFT: begin
                    // Requests arriving here are dropped without touching state.
                    wreg <= shift_by(wreg, op_q, step);
                    cnt  <= cnt_nxt;
                    if (cnt_nxt == '0) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    if (state == DONE) begin
                        res_q  <= wreg;
                        done_q <= 1'b1;
                    end
                    if (bus.start) begin
                        wreg <= bus.A;
                        op_q <= bus.op;
                        cnt  <= amt;
                        if (amt != '0) begin
                            state  <= SHIFT;
                            busy_q <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.res  = res_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed literal cases followed by randomized traffic,
// with a timeline-based reference model compared against busy/done/res every cycle.
module tb_shift_seq_ctrl;
    logic clk;
    logic rst;

    shift_seq_ctrl_if #(.DW(32)) bus ();

    shift_seq_ctrl #(.DW(32), .SAW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

`ifdef SHIFT_SEQ_FAST4_EN
    localparam int L_SRL31 = 11;
    localparam int L_SRA4  = 2;
    localparam int L_SLL8  = 3;
`else
    localparam int L_SRL31 = 32;
    localparam int L_SRA4  = 5;
    localparam int L_SLL8  = 9;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input int s);
        case (o)
            2'b00:   return a << s;
            2'b10:   return $unsigned($signed(a) >>> s);
            default: return a >> s;
        endcase
    endfunction

    function automatic int shift_cycles(input int s);
`ifdef SHIFT_SEQ_FAST4_EN
        return s / 4 + s % 4;
`else
        return s;
`endif
    endfunction

    typedef struct {
        int          edge_n;
        logic [31:0] val;
    } ev_t;

    ev_t         evq[$];
    int          busy_from = 0;
    int          busy_to   = -1;
    logic        m_busy    = 1'b0;
    logic        m_done    = 1'b0;
    logic [31:0] m_res     = '0;
    bit          m_valid   = 1'b0;

    // Model works on absolute edge numbers: an accepted request at edge k is
    // busy after edges k..k+n-1 and reports its result after edge k+n+1.
    always @(posedge clk) begin
        int s;
        int n;
        cyc++;
        if (rst) begin
            evq.delete();
            busy_to = -1;
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_res   = '0;
        end else begin
            bit accept;
            accept = bus.start && !m_busy;
            m_done = 1'b0;
            if (evq.size() > 0 && evq[0].edge_n == cyc) begin
                m_done = 1'b1;
                m_res  = evq[0].val;
                void'(evq.pop_front());
            end
            if (accept) begin
                s = int'(bus.B[10:6]);
                n = shift_cycles(s);
                evq.push_back('{cyc + n + 1, ref_shift(bus.op, bus.A, s)});
                busy_from = cyc;
                busy_to   = cyc + n - 1;
            end
            m_busy = (cyc >= busy_from) && (cyc <= busy_to);
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("res",  bus.res, m_res);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                          input logic [31:0] exp_res, input int exp_lat, input string nm);
        int lat;
        bit seen_busy;
        logic [31:0] b;
        @(negedge clk);
        b       = $urandom;
        b[10:6] = s;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(negedge clk);
        // Scramble inputs after acceptance; the in-flight result must not change.
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
        lat       = -1;
        seen_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) seen_busy = 1'b1;
            @(negedge clk);
        end
        check({nm, "_lat"},  32'(lat), 32'(exp_lat));
        check({nm, "_res"},  bus.res, exp_res);
        check({nm, "_busy"}, 32'(seen_busy), 32'(s != 5'd0));
    endtask

    task automatic wait_done(input string nm);
        int lat;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check({nm, "_timeout"}, 32'(lat), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] b;
        int pulses;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_res",  bus.res, 32'd0);
        rst = 1'b0;

        run_op(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, L_SRL31, "srl31");
        run_op(2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, L_SRA4,  "sra4");
        run_op(2'b00, 32'h0000_00FF, 5'd8,  32'h0000_FF00, L_SLL8,  "sll8");
        run_op(2'b11, 32'hF000_0000, 5'd5,  32'h0780_0000, 5'd5 == 5'd5 ? shift_cycles(5) + 1 : 0, "rsv5");
        for (int o = 0; o < 4; o++) begin
            run_op(2'(o), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1, "zero");
        end

        // Start during SHIFT is ignored; start in the done cycle is taken back-to-back.
        @(negedge clk);
        b = $urandom; b[10:6] = 5'd3;
        bus.op = 2'b00; bus.A = 32'h0000_0001; bus.B = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.A = 32'hFFFF_FFFF; bus.op = 2'b10; bus.B = '1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_first");
        check("b2b_first_res", bus.res, 32'h0000_0008);
        b = $urandom; b[10:6] = 5'd4;
        bus.op = 2'b01; bus.A = 32'h0000_00F0; bus.B = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("b2b_second");
        check("b2b_second_res", bus.res, 32'h0000_000F);

        // Reset two cycles into a 10-bit shift aborts it with no done pulse.
        @(negedge clk);
        b = $urandom; b[10:6] = 5'd10;
        bus.op = 2'b00; bus.A = 32'h1234_5678; bus.B = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_res",  bus.res, 32'd0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);

        // Randomized traffic, including starts while busy and sporadic resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 2'($urandom);
            bus.A     = $urandom;
            b         = $urandom;
            case ($urandom_range(0, 5))
                0:       b[10:6] = 5'd0;
                1:       b[10:6] = 5'd31;
                2, 3:    b[10:6] = 5'($urandom_range(0, 4));
                default: ;
            endcase
            bus.B = b;
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning operand/result width in bits; only 32 is supported.
REQ-002 The block SHALL have parameter SAW, default 5, meaning shift-amount width (log2 DW).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request strobe; sampled each rising edge.
REQ-006 Port op  input  2  shift select: 2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 reserved.
REQ-007 Port A  input  DW  operand to be shifted.
REQ-008 Port B  input  DW  instruction word; shift amount taken from B[10:6].
REQ-009 Port busy  output  1  high while a shift is in progress.
REQ-010 Port done  output  1  one-cycle pulse marking res valid.
REQ-011 Port res  output  DW  registered shift result.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 In IDLE or DONE, start=1 SHALL latch A, op, and cnt=B[10:6]; next state SHIFT if cnt!=0, else DONE.
REQ-014 In SHIFT, each cycle SHALL shift the working register by one bit (SLL: zero-fill LSB; SRL: zero-fill MSB; SRA: replicate bit 31) and decrement cnt.
REQ-015 SHIFT SHALL transition to DONE in the cycle where cnt reaches 0.
REQ-016 Latency: start accepted at edge t -> done=1 during cycle after edge t+s+1, s=B[10:6]; s=0 gives done after edge t+1.
REQ-017 DONE SHALL last exactly one cycle (done=1), then IDLE unless start=1 in that cycle (back-to-back accepted).
REQ-018 res SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-019 busy SHALL be 1 exactly in SHIFT; start while busy=1 SHALL be ignored with no effect on cnt, operands or op.
REQ-020 op=2'b11 SHALL behave as SRL.
REQ-021 A, B, op changes after acceptance SHALL not affect the result in flight.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, res=0, cnt=0, working register=0, overriding start.
REQ-023 rst asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow.

Configuration
REQ-024 Macro SHIFT_SEQ_FAST4_EN: when defined, each SHIFT cycle SHALL shift by 4 and decrement cnt by 4 while cnt>=4, else by 1; latency = floor(s/4)+(s mod 4)+1 cycles.
REQ-025 Without SHIFT_SEQ_FAST4_EN the block SHALL shift exactly 1 bit per cycle per REQ-014; results SHALL be identical in both builds.

Verification
REQ-026 SRL A=32'h8000_0000, B[10:6]=31, start at t -> busy 31 cycles, done after edge t+32, res=32'h0000_0001.
REQ-027 SRA A=32'h8000_0000, B[10:6]=4 -> done after edge t+5, res=32'hF800_0000; SLL A=32'h0000_00FF, s=8 -> res=32'h0000_FF00.
REQ-028 B[10:6]=0, A=32'hDEAD_BEEF, any op -> busy never asserted, done after edge t+1, res=32'hDEAD_BEEF.
REQ-029 Start SLL s=3 A=1; pulse start with A=32'hFFFF_FFFF during SHIFT -> ignored, res=32'h0000_0008; start during DONE -> second op accepted, done again.
REQ-030 rst=1 two cycles into an s=10 shift -> next cycle busy=0, done=0, res=0, no done pulse for 20 cycles.
REQ-031 With SHIFT_SEQ_FAST4_EN, SRL A=32'h8000_0000 s=31 -> done after edge t+11, res=32'h0000_0001.
